// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, PC increment and the fetch-buffer entry layout
// for the instruction fetch stage.
package ifetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // Every instruction is 4 bytes, so sequential fetch advances by this.
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  // One buffered fetch: the address it came from and the instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush. The head entry is read
// straight from registered storage, so dout/empty/full depend only on flops.
// Flush empties the FIFO and overrides a push in the same cycle. A push into
// a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,    // synchronous, active-high
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned (which would infer a latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        // Depth is a power of two, so the pointer wraps by overflow.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      // NOTE: the storage is reset because the head entry is visible on
      // dout even when empty, and it must read as zero out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Drives the PC onto the ROM read port,
// buffers {pc, inst} pairs in fetch_fifo and hands them to decode over a
// valid/ready handshake. A redirect re-steers the PC and flushes the buffer.
// Build option: define IFETCH_MISALIGN_TRAP_EN to make a misaligned redirect
// set a sticky fetch_fault and stop fetching until reset; otherwise the
// redirect target is force-aligned and fetch_fault is tied low.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            HCLK,
  input  logic            HRESET,
  output logic [XLEN-1:0] HADDR,
  output logic            HWRITE,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_en;
  logic            pop;
  logic            fifo_full, fifo_empty;
  logic            fault;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // Read-only port: the address is always the current PC.
  assign HADDR  = pc_q;
  assign HWRITE = 1'b0;
  assign HWDATA = '0;

  assign push_entry = '{pc: pc_q, inst: HRDATA[ILEN-1:0]};

  assign inst_valid = !fifo_empty;
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign pop        = inst_valid && inst_ready;

  // A slot is available either because the buffer has room or because
  // decode is draining the head this same cycle.
  assign fetch_en = !redirect_valid && !fault && (!fifo_full || pop);

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  logic hrdata_unused;

  assign fault         = fault_q;
  assign fetch_fault   = fault_q;
  assign hrdata_unused = ^HRDATA[XLEN-1:ILEN];

  // Next PC and sticky fault: redirect wins, misaligned targets trap.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else if (fetch_en) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC and fault registers; only reset clears the fault.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end
`else
  logic bits_unused;

  assign fault       = 1'b0;
  assign fetch_fault = 1'b0;
  assign bits_unused = ^{HRDATA[XLEN-1:ILEN], redirect_pc[1:0]};

  // Next PC: redirect wins and is force-aligned; otherwise step on fetch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fetch_en) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC register.
  always_ff @(posedge HCLK) begin
    if (HRESET) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
